serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry in, used only when sub=0.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 selects A+B+cin, 1 selects A-B.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result valid.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for sub=1, cout=1 means no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-014 The block SHALL compute with exactly one full-adder cell (Y = A^B^Cin, C = A&B | Cin&(A^B)), reused across bits, LSB first.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 On an edge in IDLE with start=1, the block SHALL latch a into its A shift register.
REQ-017 On the same edge, it SHALL latch either b (sub=0) or ~b (sub=1) into its B shift register.
REQ-018 On the same edge, it SHALL load the carry flop with cin (sub=0) or 1 (sub=1), clear the bit counter and go to RUN.
REQ-019 On each edge in RUN, the block SHALL feed the cell with the LSBs of the A and B registers and the carry flop.
REQ-020 On each such edge, it SHALL shift the cell sum into the MSB of the sum register (right shift), shift the A and B registers right, store the cell carry and increment the counter.
REQ-021 On each such edge, it SHALL also record the carry into the current bit, so the MSB carry-in is available.
REQ-022 On the RUN edge where the counter equals WIDTH-1, the block SHALL go to DONE.
REQ-023 Latency SHALL be fixed: RUN lasts exactly WIDTH cycles, and done is high in the cycle after the WIDTH-th edge following the accepting edge.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-025 In DONE and afterwards, sum SHALL be the WIDTH-bit result, cout the final carry, and ovf = (carry into MSB) XOR cout.
REQ-026 sum, cout and ovf SHALL be updated only by the final RUN edge, so no partial results are ever visible.
REQ-027 sum, cout and ovf SHALL hold their values through IDLE until the final RUN edge of the next operation.
REQ-028 start SHALL be ignored while busy=1, including the DONE cycle; there is no queuing and a, b, cin and sub are don't-care then.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH, with the carry beyond cout discarded.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and shift registers.
REQ-032 rst SHALL take priority over start in the same cycle.
REQ-033 rst asserted in RUN or DONE SHALL abort the operation, with no done pulse, and the result SHALL read zero.
REQ-034 After rst deasserts, the first start in IDLE SHALL be accepted normally.

Verification (WIDTH=4; edge E0 samples start)
REQ-035 The bench SHALL drive a=0111, b=0001, cin=0, sub=0 -> busy after E0; done=1 only between E4 and E5; sum=1000, cout=0, ovf=1.
REQ-036 The bench SHALL drive a=1111, b=0001, cin=0, sub=0 -> sum=0000, cout=1, ovf=0; with cin=1 -> sum=0001, cout=1.
REQ-037 The bench SHALL drive a=0011, b=0101, sub=1, cin=1 (ignored) -> sum=1110, cout=0, ovf=0; also a=1000, b=0001, sub=1 -> sum=0111, cout=1, ovf=1.
REQ-038 The bench SHALL pulse start=1 with new operands at E2 and during the DONE cycle of a 0010+0011 operation -> both ignored; sum=0101, one done pulse, IDLE after E5.
REQ-039 The bench SHALL assert rst at E2 of an operation -> busy=0, done=0, sum=0000 next cycle; no done pulse; a following 0001+0001 gives sum=0010.
REQ-040 The bench SHALL drive rst=1 and start=1 in the same cycle -> remains IDLE, busy=0.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder; the controller is the slave,
// whoever requests operations is the master.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB first over WIDTH
// cycles, with results published only on the last bit so no partial sum leaks.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sumSh_q, sumSh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cellY;
    logic cellC;
    logic lastBit;

    assign cellY   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    assign cellC   = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));
    assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sumSh_d = sumSh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1, so the carry flop supplies the +1.
                    aSh_d   = bus.a;
                    bSh_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
                bSh_d   = {1'b0, bSh_q[WIDTH-1:1]};
                sumSh_d = {cellY, sumSh_q[WIDTH-1:1]};
                carry_d = cellC;
                cnt_d   = cnt_q + CNT_W'(1);
                if (lastBit) begin
                    // On the last bit carry_q is the carry into the MSB.
                    sum_d   = {cellY, sumSh_q[WIDTH-1:1]};
                    cout_d  = cellC;
                    ovf_d   = carry_q ^ cellC;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sumSh_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sumSh_q <= sumSh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4: a vector table of hand-computed
// results plus hand-written sequences for ignored starts and reset aborts.
module tb_serial_add_ctrl;
    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       sub;
        logic [3:0] expSum;
        logic       expCout;
        logic       expOvf;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [3:0] heldSum  = 4'b0000;
    logic       heldCout = 1'b0;
    logic       heldOvf  = 1'b0;

    vector_t vectors [8];

    serial_add_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleHeld(input string tag);
        checkOutput({tag, " busy"}, 32'(ifc.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(ifc.done), 32'd0);
        checkOutput({tag, " sum"},  32'(ifc.sum),  32'(heldSum));
        checkOutput({tag, " cout"}, 32'(ifc.cout), 32'(heldCout));
        checkOutput({tag, " ovf"},  32'(ifc.ovf),  32'(heldOvf));
    endtask

    // Full operation with cycle-exact checks of busy/done and held results.
    task automatic applyStimulus(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, input logic sub, input logic [3:0] expSum,
                                 input logic expCout, input logic expOvf);
        ifc.a     = a;
        ifc.b     = b;
        ifc.cin   = cin;
        ifc.sub   = sub;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        checkOutput({tag, " busy after E0"}, 32'(ifc.busy), 32'd1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            checkOutput($sformatf("%s done after E%0d", tag, e), 32'(ifc.done), 32'd0);
            checkOutput($sformatf("%s sum held after E%0d", tag, e), 32'(ifc.sum), 32'(heldSum));
        end
        tick();
        checkOutput({tag, " done after E4"}, 32'(ifc.done), 32'd1);
        checkOutput({tag, " busy after E4"}, 32'(ifc.busy), 32'd1);
        checkOutput({tag, " sum"},  32'(ifc.sum),  32'(expSum));
        checkOutput({tag, " cout"}, 32'(ifc.cout), 32'(expCout));
        checkOutput({tag, " ovf"},  32'(ifc.ovf),  32'(expOvf));
        heldSum  = expSum;
        heldCout = expCout;
        heldOvf  = expOvf;
        tick();
        checkIdleHeld({tag, " after E5"});
    endtask

    initial begin
        vectors[0] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
        vectors[1] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        vectors[2] = '{4'b1111, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
        vectors[3] = '{4'b0011, 4'b0101, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0};
        vectors[4] = '{4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1};
        vectors[5] = '{4'b0101, 4'b0110, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b1};
        vectors[6] = '{4'b0101, 4'b0101, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
        vectors[7] = '{4'b1001, 4'b1010, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1};

        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.cin   = 1'b0;
        ifc.sub   = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkIdleHeld("reset");

        foreach (vectors[i]) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].cin,
                          vectors[i].sub, vectors[i].expSum, vectors[i].expCout, vectors[i].expOvf);
        end

        // Starts at E2 and during DONE are ignored
        ifc.a = 4'b0010; ifc.b = 4'b0011; ifc.cin = 1'b0; ifc.sub = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        ifc.a = 4'b1111; ifc.b = 4'b1111; ifc.cin = 1'b1; ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        checkOutput("ign done after E4", 32'(ifc.done), 32'd1);
        checkOutput("ign sum", 32'(ifc.sum), 32'h5);
        checkOutput("ign cout", 32'(ifc.cout), 32'd0);
        checkOutput("ign ovf", 32'(ifc.ovf), 32'd0);
        heldSum = 4'b0101; heldCout = 1'b0; heldOvf = 1'b0;
        ifc.a = 4'b0110; ifc.b = 4'b0001; ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        checkIdleHeld("ign after E5");
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("ign no restart c%0d", c), 32'({ifc.busy, ifc.done}), 32'd0);
        end

        // Reset at E2 aborts with no done pulse
        ifc.a = 4'b0110; ifc.b = 4'b0001; ifc.cin = 1'b0; ifc.sub = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        heldSum = 4'b0000; heldCout = 1'b0; heldOvf = 1'b0;
        checkIdleHeld("abort");
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("abort no done c%0d", c), 32'(ifc.done), 32'd0);
        end
        applyStimulus("post-abort", 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);

        // Reset beats start in the same cycle
        rst = 1'b1;
        ifc.a = 4'b0011; ifc.b = 4'b0011; ifc.start = 1'b1;
        tick();
        rst = 1'b0;
        ifc.start = 1'b0;
        heldSum = 4'b0000; heldCout = 1'b0; heldOvf = 1'b0;
        checkIdleHeld("rst+start");
        tick();
        checkIdleHeld("rst+start later");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
